// File: rtl/note_store_player.sv
`default_nettype none
// ============================================================================
// note_store_player: song buffer that stores notes, paces inserts with a settle
// delay and plays the song back at a fixed note duration.
// Optional silent gap between notes: define COMPOSER_REST_GAP_EN.
// Revision: 1.0
// ============================================================================
module note_store_player #(
  parameter int DEPTH       = 16,
  parameter int NOTE_W      = 4,
  parameter int NOTE_CYCLES = 25_000_000,
  parameter int INS_CYCLES  = 12_500_000,
  parameter int GAP_CYCLES  = 2_500_000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     insert_en,
  input  logic                     delete_en,
  input  logic                     play_en,
  input  logic [NOTE_W-1:0]        note_in,
  output logic                     is_full,
  output logic                     is_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     insert_delay_done,
  output logic                     play_done,
  output logic [NOTE_W-1:0]        note_out,
  output logic                     note_valid,
  output logic                     busy
);

  localparam int CW     = $clog2(DEPTH) + 1;
  localparam int IW     = $clog2(DEPTH);
  localparam int MAX_NI = (NOTE_CYCLES > INS_CYCLES) ? NOTE_CYCLES : INS_CYCLES;
  localparam int MAXC   = (MAX_NI > GAP_CYCLES) ? MAX_NI : GAP_CYCLES;
  localparam int TW     = $clog2(MAXC) + 1;

  localparam logic [CW-1:0] c_full      = CW'(DEPTH);
  localparam logic [TW-1:0] c_note_load = TW'(NOTE_CYCLES - 1);
  localparam logic [TW-1:0] c_ins_load  = TW'(INS_CYCLES - 1);
`ifdef COMPOSER_REST_GAP_EN
  localparam logic [TW-1:0] c_gap_load  = TW'(GAP_CYCLES - 1);
`endif

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_INS_WAIT  = 2'd1;
  localparam logic [1:0] S_PLAY_NOTE = 2'd2;
`ifdef COMPOSER_REST_GAP_EN
  localparam logic [1:0] S_PLAY_GAP  = 2'd3;
`endif

  logic [1:0]        r_state, w_state_next;
  logic              r_insert_q, r_delete_q, r_play_q;
  logic              w_ins_req, w_del_req, w_play_req;
  logic [NOTE_W-1:0] r_mem [DEPTH];
  logic [CW-1:0]     r_count, w_count_next;
  logic [IW-1:0]     r_idx, w_idx_next, w_idx_inc;
  logic [TW-1:0]     r_timer, w_timer_next;
  logic              w_mem_we, w_last;
  logic              r_is_full, r_is_empty, r_busy;
  logic              r_ins_done, w_ins_done_next;
  logic              r_play_done, w_play_done_next;
  logic [NOTE_W-1:0] r_note_out, w_note_next;
  logic              r_note_valid, w_valid_next;

  assign w_ins_req  = insert_en & ~r_insert_q;
  assign w_del_req  = delete_en & ~r_delete_q;
  assign w_play_req = play_en   & ~r_play_q;
  assign w_last     = ({1'b0, r_idx} == (r_count - CW'(1)));
  assign w_idx_inc  = r_idx + IW'(1);

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_del_req)                               w_state_next = S_IDLE;
        else if (w_ins_req)                          w_state_next = S_INS_WAIT;
        else if (w_play_req && (r_count != '0))      w_state_next = S_PLAY_NOTE;
      end
      S_INS_WAIT:
        if (r_timer == '0) w_state_next = S_IDLE;
      S_PLAY_NOTE:
        if (r_timer == '0) begin
          if (w_last) w_state_next = S_IDLE;
`ifdef COMPOSER_REST_GAP_EN
          else        w_state_next = S_PLAY_GAP;
`else
          else        w_state_next = S_PLAY_NOTE;
`endif
        end
`ifdef COMPOSER_REST_GAP_EN
      S_PLAY_GAP:
        if (r_timer == '0) w_state_next = S_PLAY_NOTE;
`endif
      default: w_state_next = S_IDLE;
    endcase
  end

  // Next values of every registered output and of the datapath registers.
  always_comb begin
    w_count_next     = r_count;
    w_idx_next       = r_idx;
    w_timer_next     = r_timer;
    w_mem_we         = 1'b0;
    w_ins_done_next  = 1'b0;
    w_play_done_next = 1'b0;
    w_note_next      = '0;
    w_valid_next     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_del_req) begin
          if (r_count != '0) w_count_next = r_count - CW'(1);
        end else if (w_ins_req) begin
          w_timer_next = c_ins_load;
          if (!r_is_full) begin
            w_mem_we     = 1'b1;
            w_count_next = r_count + CW'(1);
          end
        end else if (w_play_req) begin
          if (r_count != '0) begin
            w_idx_next   = '0;
            w_timer_next = c_note_load;
            w_note_next  = r_mem[0];
            w_valid_next = 1'b1;
          end else begin
            w_play_done_next = 1'b1;
          end
        end
      end
      S_INS_WAIT: begin
        if (r_timer == '0) w_ins_done_next = 1'b1;
        else               w_timer_next    = r_timer - TW'(1);
      end
      S_PLAY_NOTE: begin
        if (r_timer == '0) begin
          if (w_last) begin
            w_play_done_next = 1'b1;
          end else begin
`ifdef COMPOSER_REST_GAP_EN
            w_timer_next = c_gap_load;
`else
            w_idx_next   = w_idx_inc;
            w_timer_next = c_note_load;
            w_note_next  = r_mem[w_idx_inc];
            w_valid_next = 1'b1;
`endif
          end
        end else begin
          w_timer_next = r_timer - TW'(1);
          w_note_next  = r_mem[r_idx];
          w_valid_next = 1'b1;
        end
      end
`ifdef COMPOSER_REST_GAP_EN
      S_PLAY_GAP: begin
        if (r_timer == '0) begin
          w_idx_next   = w_idx_inc;
          w_timer_next = c_note_load;
          w_note_next  = r_mem[w_idx_inc];
          w_valid_next = 1'b1;
        end else begin
          w_timer_next = r_timer - TW'(1);
        end
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_insert_q   <= 1'b0;
      r_delete_q   <= 1'b0;
      r_play_q     <= 1'b0;
      r_count      <= '0;
      r_idx        <= '0;
      r_timer      <= '0;
      r_is_full    <= 1'b0;
      r_is_empty   <= 1'b1;
      r_busy       <= 1'b0;
      r_ins_done   <= 1'b0;
      r_play_done  <= 1'b0;
      r_note_out   <= '0;
      r_note_valid <= 1'b0;
    end else begin
      r_insert_q   <= insert_en;
      r_delete_q   <= delete_en;
      r_play_q     <= play_en;
      r_count      <= w_count_next;
      r_idx        <= w_idx_next;
      r_timer      <= w_timer_next;
      r_is_full    <= (w_count_next == c_full);
      r_is_empty   <= (w_count_next == '0);
      r_busy       <= (w_state_next != S_IDLE);
      r_ins_done   <= w_ins_done_next;
      r_play_done  <= w_play_done_next;
      r_note_out   <= w_note_next;
      r_note_valid <= w_valid_next;
    end
  end

  // Song memory is not reset; slots above count are never read.
  always_ff @(posedge clk) begin
    if (!reset && w_mem_we) r_mem[r_count[IW-1:0]] <= note_in;
  end

  assign is_full           = r_is_full;
  assign is_empty          = r_is_empty;
  assign count             = r_count;
  assign insert_delay_done = r_ins_done;
  assign play_done         = r_play_done;
  assign note_out          = r_note_out;
  assign note_valid        = r_note_valid;
  assign busy              = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_note_store_player.sv
`default_nettype none
// Self-checking bench for note_store_player: directed test-plan sequences plus
// random request mixes, checked against a queue-based song model.
module tb_note_store_player;

  localparam int DEPTH = 4;
  localparam int NOTE  = 3;
  localparam int INS   = 2;
  localparam int GAP   = 2;
`ifdef COMPOSER_REST_GAP_EN
  localparam int G = GAP;
`else
  localparam int G = 0;
`endif

  logic       clk = 1'b0;
  logic       reset, insert_en, delete_en, play_en;
  logic [3:0] note_in;
  logic       is_full, is_empty, insert_delay_done, play_done, note_valid, busy;
  logic [2:0] count;
  logic [3:0] note_out;

  int n_vec = 0;
  int n_err = 0;
  logic [3:0] song[$];

  note_store_player #(
    .DEPTH(DEPTH), .NOTE_W(4), .NOTE_CYCLES(NOTE), .INS_CYCLES(INS), .GAP_CYCLES(GAP)
  ) dut (
    .clk(clk), .reset(reset), .insert_en(insert_en), .delete_en(delete_en),
    .play_en(play_en), .note_in(note_in), .is_full(is_full), .is_empty(is_empty),
    .count(count), .insert_delay_done(insert_delay_done), .play_done(play_done),
    .note_out(note_out), .note_valid(note_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  // Issues one request mix at a negedge (cycle 0), holds the enables for `hold`
  // cycles and checks every output each cycle. rst_at > 0 pulses reset then.
  task automatic do_req(input bit ins, input bit del, input bit ply,
                        input logic [3:0] nt, input int hold, input int rst_at);
    int kind, n, tend, w, j, r;
    bit aborted;
    logic       e_ins, e_pd, e_busy, e_valid;
    logic [3:0] e_note;
    aborted = 0;
    n = 0;
    insert_en = ins; delete_en = del; play_en = ply; note_in = nt;
    if (del) begin
      kind = 0; tend = INS + 2;
      if (song.size() > 0) void'(song.pop_back());
    end else if (ins) begin
      kind = 1; tend = INS + 1;
      if (song.size() < DEPTH) song.push_back(nt);
    end else if (ply) begin
      kind = 2; n = song.size();
      tend = (n == 0) ? 1 : n * NOTE + (n - 1) * G + 1;
    end else begin
      kind = 3; tend = 1;
    end
    w = ((tend > hold) ? tend : hold) + 1;
    for (int k = 1; k <= w; k++) begin
      @(negedge clk);
      e_ins = 0; e_pd = 0; e_busy = 0; e_valid = 0; e_note = '0;
      if (!aborted) begin
        if (kind == 1) begin
          e_ins  = (k == INS + 1);
          e_busy = (k <= INS);
        end else if (kind == 2) begin
          e_pd = (k == tend);
          if (n > 0 && k < tend) begin
            e_busy  = 1;
            j       = (k - 1) / (NOTE + G);
            r       = (k - 1) % (NOTE + G);
            e_valid = (r < NOTE);
            e_note  = e_valid ? song[j] : 4'd0;
          end
        end
      end
      check("count", count, song.size());
      check("is_full", is_full, song.size() == DEPTH);
      check("is_empty", is_empty, song.size() == 0);
      check("insert_delay_done", insert_delay_done, e_ins);
      check("play_done", play_done, e_pd);
      check("busy", busy, e_busy);
      check("note_valid", note_valid, e_valid);
      check("note_out", note_out, e_note);
      if (k == hold) begin
        insert_en = 0; delete_en = 0; play_en = 0;
      end
      if (aborted && reset) reset = 0;
      if (k == rst_at) begin
        reset = 1;
        aborted = 1;
        song.delete();
      end
    end
    reset = 0;
  endtask

  initial begin
    reset = 1; insert_en = 0; delete_en = 0; play_en = 0; note_in = '0;
    repeat (3) @(negedge clk);
    check("rst_count", count, 0);
    check("rst_is_empty", is_empty, 1);
    check("rst_is_full", is_full, 0);
    check("rst_busy", busy, 0);
    check("rst_note_valid", note_valid, 0);
    check("rst_note_out", note_out, 0);
    check("rst_ins_done", insert_delay_done, 0);
    check("rst_play_done", play_done, 0);
    reset = 0;
    @(negedge clk);

    // Fill; the last insert holds its enable for 10 cycles.
    do_req(1, 0, 0, 4'd5, 1, 0);
    do_req(1, 0, 0, 4'd7, 1, 0);
    do_req(1, 0, 0, 4'd9, 1, 0);
    do_req(1, 0, 0, 4'd11, 10, 0);
    // Overflow then play the full song (mem[3] must still be 11).
    do_req(1, 0, 0, 4'd13, 1, 0);
    do_req(0, 0, 1, 4'd0, 1, 0);
    // Delete down to empty with one extra delete.
    repeat (5) do_req(0, 1, 0, 4'd0, 1, 0);
    do_req(0, 0, 1, 4'd0, 1, 0);
    // Playback of [5, 7, 9].
    do_req(1, 0, 0, 4'd5, 1, 0);
    do_req(1, 0, 0, 4'd7, 1, 0);
    do_req(1, 0, 0, 4'd9, 1, 0);
    do_req(0, 0, 1, 4'd0, 1, 0);
    // Simultaneous delete and insert: delete wins.
    do_req(1, 1, 0, 4'd3, 1, 0);
    // Reset during cycle 5 of playback.
    do_req(0, 0, 1, 4'd0, 1, 5);

    for (int i = 0; i < 60; i++) begin
      logic [2:0] m;
      m = 3'($urandom_range(0, 7));
      do_req(m[0], m[1], m[2], 4'($urandom_range(0, 15)), int'($urandom_range(1, 3)), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/note_store_player.md
# note_store_player

Song-buffer datapath for the composer. It responds to the controller's enables: insert, delete and play. It stores up to DEPTH notes entered by the user, reports fill status, and paces each insert with a settle delay. On request it plays the stored song back one note at a time at a fixed note duration. It returns the status handshakes the controller waits on: `is_full`, `insert_delay_done` and `play_done`.

## Interface
- `DEPTH`, 16: song capacity in notes; power of two, ≥2.
- `NOTE_W`, 4: note code width.
- `NOTE_CYCLES`, 25_000_000: clock cycles each note is held during playback; ≥1.
- `INS_CYCLES`, 12_500_000: insert settle delay in cycles; ≥1.
- `GAP_CYCLES`, 2_500_000: silent cycles between notes; used only with `COMPOSER_REST_GAP_EN`; ≥1.

Ports:
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `insert_en` in 1: level from controller; a rising edge requests an insert.
- `delete_en` in 1: level; a rising edge requests removal of the last note.
- `play_en` in 1: level; a rising edge requests playback.
- `note_in` in NOTE_W: note to insert; sampled in the edge cycle.
- `is_full` out 1: high when count == DEPTH.
- `is_empty` out 1: high when count == 0.
- `count` out $clog2(DEPTH)+1: notes stored.
- `insert_delay_done` out 1: one-cycle pulse at the end of the insert settle.
- `play_done` out 1: one-cycle pulse at the end of playback.
- `note_out` out NOTE_W: current playback note; holds 0 when `note_valid` is low.
- `note_valid` out 1: high while a note is sounding.
- `busy` out 1: high in any state other than IDLE.

## Operation
- Each enable is registered once. Request = en & ~en_q. A held level never retriggers.
- Requests are acted on only in IDLE. Requests arriving in other states are dropped.
- Priority for simultaneous edges in IDLE: delete > insert > play.
- States: IDLE, INS_WAIT, PLAY_NOTE, PLAY_GAP (PLAY_GAP exists only with the macro).
- Insert, not full: write mem[count] = note_in, increment count, load the delay counter, go to INS_WAIT.
- Insert, full: no write, count unchanged, still go to INS_WAIT. The controller always receives `insert_delay_done`.
- INS_WAIT: counts INS_CYCLES, then pulses `insert_delay_done` and returns to IDLE.
- Delete with count > 0: decrement count; stay in IDLE. Delete on empty: no effect.
- Play with count > 0: index = 0, go to PLAY_NOTE, output mem[index] for NOTE_CYCLES.
  - Then advance the index. After the last note, go to IDLE and pulse `play_done`.
- Play on empty: pulse `play_done` only; `note_valid` never asserts.
- Playback does not modify count or memory.
- Reset values: count = 0, state IDLE, all outputs 0 except `is_empty` = 1. Memory contents are not reset; they are unreachable while count = 0.
- Reset mid-operation clears everything on the next edge: the song is cleared, and no pending pulse is emitted.
- Counters are wide enough for the parameter maxima. The index never exceeds count−1.

## Timing
Cycle 0 is the cycle in which the request edge is sampled.
- Insert:
  - count and `is_full` update in cycle 1.
  - `insert_delay_done` is high in cycle INS_CYCLES+1 only; the block is IDLE that cycle and accepts new requests.
- Delete: count updates in cycle 1.
- Play, no gap:
  - Note k is on `note_out` with `note_valid` = 1 in cycles 1+k·NOTE_CYCLES through (k+1)·NOTE_CYCLES.
  - `play_done` is high in cycle count·NOTE_CYCLES+1, with `note_valid` = 0.
- Play on empty: `play_done` is high in cycle 1.
- All outputs are registered. No combinational path exists from inputs to outputs.

## Configuration
- `COMPOSER_REST_GAP_EN` defined:
  - After every note except the last, enter PLAY_GAP for GAP_CYCLES with `note_valid` = 0 and `note_out` = 0.
  - Note k starts at cycle 1+k·(NOTE_CYCLES+GAP_CYCLES).
  - `play_done` is high at count·NOTE_CYCLES+(count−1)·GAP_CYCLES+1.
- `COMPOSER_REST_GAP_EN` undefined: notes are back-to-back, PLAY_GAP is not built, and `GAP_CYCLES` is ignored.

## Test plan
Bench parameters: DEPTH=4, NOTE_CYCLES=3, INS_CYCLES=2, GAP_CYCLES=2.
- Fill: reset, then insert 5, 7, 9, 11, each edge after the previous `insert_delay_done` → count 1→4, `is_full` = 1 after the fourth, each `insert_delay_done` 3 cycles after its edge. Hold `insert_en` high 10 cycles → exactly one insert.
- Overflow: fifth insert of 13 while full → count stays 4, mem[3] = 11, `insert_delay_done` still pulses at cycle 3.
- Delete: two delete edges → count 2. Then delete to 0, plus one extra delete → count 0, `is_empty` = 1, no underflow.
- Playback (macro off), song [5, 7, 9] → `note_out` 5 in cycles 1–3, 7 in 4–6, 9 in 7–9; `play_done` in cycle 10 only.
- Playback (macro on), same song → 5 in cycles 1–3, gap 4–5, 7 in 6–8, gap 9–10, 9 in 11–13; `play_done` in cycle 14.
- Play on empty → `play_done` in cycle 1, `note_valid` never high.
- Reset during cycle 5 of playback → next cycle `note_valid` = 0, `busy` = 0, count = 0, no `play_done`.
- Simultaneous delete and insert edges → delete only, no `insert_delay_done`.
